// File: rtl/sha256_pkg.sv
// Shared SHA-256 message-schedule definitions: word type, block/round sizes,
// the round-constant table, the scheduler state encoding and the small sigma
// functions used by the expansion adder.
package sha256_pkg;

    typedef logic [31:0] word_t;
    typedef logic [5:0]  round_t;

    localparam int N_BLOCK_WORDS = 16;
    localparam int N_ROUNDS      = 64;

    typedef enum logic {
        ST_LOAD,
        ST_STREAM
    } sched_state_e;

    // Round constants K_0..K_63.
    localparam word_t K [N_ROUNDS] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // sigma0: ROTR7 ^ ROTR18 ^ SHR3
    function automatic word_t s0(input word_t x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    // sigma1: ROTR17 ^ ROTR19 ^ SHR10
    function automatic word_t s1(input word_t x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

endpackage

// File: rtl/mod_message_scheduler_if.sv
// Load and W-stream handshake bundle between the padded-message source,
// the message scheduler and the compressor.
interface mod_message_scheduler_if;
    import sha256_pkg::*;

    logic   LOAD_VALID;
    logic   LOAD_READY;
    word_t  LOAD_WORD;
    logic   W_VALID;
    logic   W_READY;
    word_t  W_OUT;
    round_t W_INDEX;
    logic   BLOCK_DONE;

    // Environment side: supplies message words and consumes the W stream.
    modport master (
        output LOAD_VALID, LOAD_WORD, W_READY,
        input  LOAD_READY, W_VALID, W_OUT, W_INDEX, BLOCK_DONE
    );

    // Scheduler side.
    modport slave (
        input  LOAD_VALID, LOAD_WORD, W_READY,
        output LOAD_READY, W_VALID, W_OUT, W_INDEX, BLOCK_DONE
    );
endinterface

// File: rtl/mod_sched_expand.sv
// Combinational expansion of the next schedule word from the sliding window:
// W_{t+16} = s1(W_{t+14}) + W_{t+9} + s0(W_{t+1}) + W_t, modulo 2^32.
module mod_sched_expand
    import sha256_pkg::*;
(
    input  word_t w0_i,
    input  word_t w1_i,
    input  word_t w9_i,
    input  word_t w14_i,
    output word_t w16_o
);
    // Carries out of bit 31 fall off the 32-bit result.
    assign w16_o = s1(w14_i) + w9_i + s0(w1_i) + w0_i;
endmodule

// File: rtl/mod_message_scheduler.sv
// SHA-256 message scheduler: loads sixteen message words, then streams
// W_0..W_63 with their round index, expanding from a 16-word sliding window.
// Optional feature macro: SHA_SCHED_K_EN adds the K_OUT round-constant port.
module mod_message_scheduler
    import sha256_pkg::*;
(
    input  logic                    CLK,
    input  logic                    RESET,
    mod_message_scheduler_if.slave  bus
`ifdef SHA_SCHED_K_EN
    ,
    output word_t                   K_OUT
`endif
);

    sched_state_e state_q;
    logic [3:0]   cnt_q;
    round_t       idx_q;
    logic         done_q;
    word_t        win_q [N_BLOCK_WORDS];
    word_t        win15_d;

    mod_sched_expand u_expand (
        .w0_i  (win_q[0]),
        .w1_i  (win_q[1]),
        .w9_i  (win_q[9]),
        .w14_i (win_q[14]),
        .w16_o (win15_d)
    );

    // FSM, load counter, round index, window and the done pulse in one block.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            // NOTE: the window is reset because W_OUT must read zero out of reset.
            for (int i = 0; i < N_BLOCK_WORDS; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            // NOTE: done_q defaults low each cycle so it is a single-cycle pulse.
            done_q <= 1'b0;
            case (state_q)
                ST_LOAD: begin
                    if (bus.LOAD_VALID) begin
                        win_q[cnt_q] <= bus.LOAD_WORD;
                        if (cnt_q == 4'(N_BLOCK_WORDS - 1)) begin
                            cnt_q   <= '0;
                            idx_q   <= '0;
                            state_q <= ST_STREAM;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end
                ST_STREAM: begin
                    if (bus.W_READY) begin
                        for (int i = 0; i < N_BLOCK_WORDS - 1; i++) begin
                            win_q[i] <= win_q[i + 1];
                        end
                        // Words appended beyond t=47 are never emitted.
                        win_q[N_BLOCK_WORDS - 1] <= win15_d;
                        if (idx_q == round_t'(N_ROUNDS - 1)) begin
                            idx_q   <= '0;
                            cnt_q   <= '0;
                            done_q  <= 1'b1;
                            state_q <= ST_LOAD;
                        end else begin
                            idx_q <= idx_q + round_t'(1);
                        end
                    end
                end
                default: state_q <= ST_LOAD;
            endcase
        end
    end

    // Outputs are state decodes or register reads; W_READY never reaches them.
    assign bus.LOAD_READY = (state_q == ST_LOAD);
    assign bus.W_VALID    = (state_q == ST_STREAM);
    assign bus.W_OUT      = win_q[0];
    assign bus.W_INDEX    = idx_q;
    assign bus.BLOCK_DONE = done_q;

`ifdef SHA_SCHED_K_EN
    // Round constant follows the emitted index.
    assign K_OUT = K[idx_q];
`endif

endmodule

// File: tb/tb_mod_message_scheduler.sv
// Directed testbench for mod_message_scheduler: reset values, expansion of
// hand-computed blocks, back-to-back loading, stalls and mid-stream reset.
module tb_mod_message_scheduler;
    import sha256_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mod_message_scheduler_if bus ();

`ifdef SHA_SCHED_K_EN
    word_t k_out;
`endif

    mod_message_scheduler dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
`ifdef SHA_SCHED_K_EN
        ,
        .K_OUT (k_out)
`endif
    );

    int     checks = 0;
    int     errors = 0;
    word_t  blk     [16];
    word_t  exp_w   [64];
    word_t  got_w   [64];
    round_t got_idx [64];
    int     n_got, done_cnt, stall_bad, stall_cnt;

    // Independent reference of the schedule recursion.
    function automatic word_t ref_rotr(input word_t x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t ref_s0(input word_t x);
        return ref_rotr(x, 7) ^ ref_rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t ref_s1(input word_t x);
        return ref_rotr(x, 17) ^ ref_rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic build_ref;
        for (int t = 0; t < 16; t++) exp_w[t] = blk[t];
        for (int t = 16; t < 64; t++)
            exp_w[t] = ref_s1(exp_w[t-2]) + exp_w[t-7] + ref_s0(exp_w[t-15]) + exp_w[t-16];
    endtask

    task automatic clear_blk;
        for (int i = 0; i < 16; i++) blk[i] = '0;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Presents blk[0..15], one word per cycle.
    task automatic load_block;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (bus.LOAD_READY !== 1'b1) begin
                errors++;
                $display("FAIL load_ready word %0d: got %b want 1", i, bus.LOAD_READY);
            end
            bus.LOAD_VALID = 1'b1;
            bus.LOAD_WORD  = blk[i];
            step();
        end
        bus.LOAD_VALID = 1'b0;
        bus.LOAD_WORD  = '0;
    endtask

    // Consumes n_take words, optionally with a fixed stall pattern, recording
    // words, indices, done pulses and any change seen during a stall.
    task automatic run_stream(input bit stall, input int n_take);
        int     cyc = 0;
        logic   prev_stall = 1'b0;
        word_t  prev_w = '0;
        round_t prev_i = '0;
        n_got = 0; done_cnt = 0; stall_bad = 0; stall_cnt = 0;
        while (n_got < n_take && cyc < 1000) begin
            if (prev_stall && (bus.W_OUT !== prev_w || bus.W_INDEX !== prev_i)) stall_bad++;
            bus.W_READY = stall ? ((cyc % 3) != 1 && (cyc % 7) != 4) : 1'b1;
            if (bus.W_VALID === 1'b1 && bus.W_READY) begin
                got_w[n_got]   = bus.W_OUT;
                got_idx[n_got] = bus.W_INDEX;
                n_got++;
            end
            prev_stall = (bus.W_VALID === 1'b1) && !bus.W_READY;
            if (prev_stall) stall_cnt++;
            prev_w = bus.W_OUT;
            prev_i = bus.W_INDEX;
            step();
            cyc++;
            if (bus.BLOCK_DONE === 1'b1) done_cnt++;
        end
        bus.W_READY = 1'b0;
        checks++;
        if (n_got != n_take) begin
            errors++;
            $display("FAIL stream_budget: got %0d words want %0d", n_got, n_take);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        checks++; if (bus.LOAD_READY !== 1'b1) begin errors++; $display("FAIL rst_load_ready: got %b want 1", bus.LOAD_READY); end
        checks++; if (bus.W_VALID !== 1'b0) begin errors++; $display("FAIL rst_w_valid: got %b want 0", bus.W_VALID); end
        checks++; if (bus.W_OUT !== 32'h0) begin errors++; $display("FAIL rst_w_out: got %h want 0", bus.W_OUT); end
        checks++; if (bus.W_INDEX !== 6'd0) begin errors++; $display("FAIL rst_w_index: got %0d want 0", bus.W_INDEX); end
        checks++; if (bus.BLOCK_DONE !== 1'b0) begin errors++; $display("FAIL rst_block_done: got %b want 0", bus.BLOCK_DONE); end
`ifdef SHA_SCHED_K_EN
        checks++; if (k_out !== 32'h428a2f98) begin errors++; $display("FAIL rst_k_out: got %h want 428a2f98", k_out); end
`endif
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_all_zero;
        clear_blk();
        load_block();
        checks++; if (bus.W_VALID !== 1'b1) begin errors++; $display("FAIL zero_first_valid: got %b want 1", bus.W_VALID); end
        run_stream(1'b0, 64);
        for (int t = 0; t < 64; t++) begin
            checks++;
            if (got_w[t] !== 32'h0 || got_idx[t] !== round_t'(t)) begin
                errors++;
                $display("FAIL zero_word %0d: got %h idx %0d want 00000000 idx %0d", t, got_w[t], got_idx[t], t);
            end
        end
        checks++; if (bus.BLOCK_DONE !== 1'b1) begin errors++; $display("FAIL zero_done_pulse: got %b want 1", bus.BLOCK_DONE); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL zero_done_count: got %0d want 1", done_cnt); end
        checks++; if (bus.LOAD_READY !== 1'b1 || bus.W_VALID !== 1'b0) begin errors++; $display("FAIL zero_back_to_load: ready %b valid %b want 1 0", bus.LOAD_READY, bus.W_VALID); end
        checks++; if (bus.W_INDEX !== 6'd0) begin errors++; $display("FAIL zero_index_wrap: got %0d want 0", bus.W_INDEX); end
        step();
        checks++; if (bus.BLOCK_DONE !== 1'b0) begin errors++; $display("FAIL zero_done_width: got %b want 0", bus.BLOCK_DONE); end
    endtask

`ifdef SHA_SCHED_K_EN
    task automatic test_k;
        clear_blk();
        load_block();
        checks++; if (k_out !== 32'h428a2f98) begin errors++; $display("FAIL k_index0: got %h want 428a2f98", k_out); end
        run_stream(1'b0, 63);
        checks++; if (bus.W_INDEX !== 6'd63) begin errors++; $display("FAIL k_at63_index: got %0d want 63", bus.W_INDEX); end
        checks++; if (k_out !== 32'hc67178f2) begin errors++; $display("FAIL k_index63: got %h want c67178f2", k_out); end
        bus.W_READY = 1'b1;
        step();
        bus.W_READY = 1'b0;
        checks++; if (bus.BLOCK_DONE !== 1'b1) begin errors++; $display("FAIL k_done: got %b want 1", bus.BLOCK_DONE); end
        step();
    endtask
`endif

    task automatic test_m0_one;
        clear_blk();
        blk[0] = 32'h00000001;
        load_block();
        run_stream(1'b0, 64);
        checks++; if (got_w[0] !== 32'h00000001) begin errors++; $display("FAIL m0_w0: got %h want 00000001", got_w[0]); end
        checks++; if (got_w[16] !== 32'h00000001) begin errors++; $display("FAIL m0_w16: got %h want 00000001", got_w[16]); end
        checks++; if (got_w[17] !== 32'h00000000) begin errors++; $display("FAIL m0_w17: got %h want 00000000", got_w[17]); end
        checks++; if (got_w[18] !== 32'h0000a000) begin errors++; $display("FAIL m0_w18: got %h want 0000a000", got_w[18]); end
        checks++; if (got_idx[18] !== 6'd18) begin errors++; $display("FAIL m0_idx18: got %0d want 18", got_idx[18]); end
    endtask

    // Starts loading in the BLOCK_DONE cycle left by the previous block.
    task automatic test_back_to_back;
        checks++; if (bus.BLOCK_DONE !== 1'b1) begin errors++; $display("FAIL b2b_done_cycle: got %b want 1", bus.BLOCK_DONE); end
        clear_blk();
        blk[1] = 32'h00000001;
        load_block();
        run_stream(1'b0, 64);
        checks++; if (got_w[0] !== 32'h00000000) begin errors++; $display("FAIL b2b_w0: got %h want 00000000", got_w[0]); end
        checks++; if (got_w[1] !== 32'h00000001) begin errors++; $display("FAIL b2b_w1: got %h want 00000001", got_w[1]); end
        checks++; if (got_w[16] !== 32'h02004000) begin errors++; $display("FAIL b2b_w16: got %h want 02004000", got_w[16]); end
        checks++; if (got_w[17] !== 32'h00000001) begin errors++; $display("FAIL b2b_w17: got %h want 00000001", got_w[17]); end
        step();
    endtask

    task automatic set_hello;
        clear_blk();
        blk[0]  = 32'h48656c6c;
        blk[1]  = 32'h6f20776f;
        blk[2]  = 32'h726c6421;
        blk[3]  = 32'h80000000;
        blk[15] = 32'h00000060;
    endtask

    task automatic test_hello_stalls;
        set_hello();
        build_ref();
        load_block();
        run_stream(1'b1, 64);
        for (int t = 0; t < 64; t++) begin
            checks++;
            if (got_w[t] !== exp_w[t] || got_idx[t] !== round_t'(t)) begin
                errors++;
                $display("FAIL hello_word %0d: got %h idx %0d want %h idx %0d", t, got_w[t], got_idx[t], exp_w[t], t);
            end
        end
        checks++; if (stall_bad != 0) begin errors++; $display("FAIL hello_stall_hold: got %0d changes want 0", stall_bad); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL hello_done_count: got %0d want 1", done_cnt); end
        step();
    endtask

    task automatic test_reset_mid_stream;
        set_hello();
        load_block();
        run_stream(1'b0, 30);
        checks++; if (bus.W_INDEX !== 6'd30) begin errors++; $display("FAIL mid_index: got %0d want 30", bus.W_INDEX); end
        rst = 1'b1;
        #1;
        checks++; if (bus.LOAD_READY !== 1'b1 || bus.W_VALID !== 1'b0) begin errors++; $display("FAIL mid_rst_hs: ready %b valid %b want 1 0", bus.LOAD_READY, bus.W_VALID); end
        checks++; if (bus.W_OUT !== 32'h0 || bus.W_INDEX !== 6'd0) begin errors++; $display("FAIL mid_rst_out: got %h idx %0d want 00000000 idx 0", bus.W_OUT, bus.W_INDEX); end
        step();
        rst = 1'b0;
        clear_blk();
        load_block();
        run_stream(1'b0, 64);
        for (int t = 0; t < 64; t++) begin
            checks++;
            if (got_w[t] !== 32'h0 || got_idx[t] !== round_t'(t)) begin
                errors++;
                $display("FAIL mid_after_word %0d: got %h idx %0d want 00000000 idx %0d", t, got_w[t], got_idx[t], t);
            end
        end
        step();
    endtask

    initial begin
        rst            = 1'b0;
        bus.LOAD_VALID = 1'b0;
        bus.LOAD_WORD  = '0;
        bus.W_READY    = 1'b0;
        test_reset();
        test_all_zero();
`ifdef SHA_SCHED_K_EN
        test_k();
`endif
        test_m0_one();
        test_back_to_back();
        test_hello_stalls();
        test_reset_mid_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
